rr_arb_mux: RTL and testbench

- Parametrised, registered N:1 arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Selects one of NUM_IN requesters per cycle, using round-robin or fixed-priority arbitration, and holds the winner in a one-entry output buffer.
- Sustains one transfer per cycle.
- Sits between multiple request sources (e.g. icache/dcache refill, MMIO) and a single shared memory or bus port.

---
 rtl/rr_arb_mux.sv | 131 +++++++++++++
 tb/tb_rr_arb_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 arbitrating multiplexer with valid/ready on every side.
// One requester is granted per cycle (round-robin or fixed priority) and its
// word is captured in a single-entry output buffer, so the output is fully
// registered and a new word can load in the same cycle the old one drains.
module rr_arb_mux #(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 32,
  parameter int RR_MODE = 1,
  parameter int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Buffer and pointer state.
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  // Arbitration results.
  logic              load_en_s;
  logic [NUM_IN-1:0] grant_s;
  logic              found_s;
  logic [SEL_W-1:0]  gnt_idx_s;
  logic [SEL_W:0]    dist_s;
  logic [SEL_W:0]    best_dist_s;
  logic [WIDTH-1:0]  win_data_s;

  // The buffer may accept a word when empty or when its word leaves this cycle.
  assign load_en_s = !valid_q || out_ready;

  // Grant search: each channel's distance from ptr (or its index in fixed
  // priority mode) is its priority; the valid channel with the smallest wins.
  always_comb begin
    found_s     = 1'b0;
    gnt_idx_s   = '0;
    best_dist_s = '0;
    dist_s      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (RR_MODE != 0) begin
        if ((SEL_W+1)'(i) >= {1'b0, ptr_q}) begin
          dist_s = (SEL_W+1)'(i) - {1'b0, ptr_q};
        end else begin
          dist_s = (SEL_W+1)'(i) + (SEL_W+1)'(NUM_IN) - {1'b0, ptr_q};
        end
      end else begin
        dist_s = (SEL_W+1)'(i);
      end
      if (in_valid[i] && (!found_s || (dist_s < best_dist_s))) begin
        found_s     = 1'b1;
        best_dist_s = dist_s;
        gnt_idx_s   = SEL_W'(i);
      end else begin
        found_s     = found_s;
      end
    end
  end

  // One-hot grant vector and the winning channel's data.
  always_comb begin
    grant_s    = '0;
    win_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant_s[i] = found_s && (gnt_idx_s == SEL_W'(i));
      if (grant_s[i]) begin
        win_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Accept strobes are independent of in_data and held low while in reset.
  assign in_ready = {NUM_IN{load_en_s && !rst}} & grant_s;

  // Next-state for the output buffer and the round-robin pointer.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en_s) begin
      if (found_s) begin
        data_d  = win_data_s;
        sel_d   = gnt_idx_s;
        valid_d = 1'b1;
        if (RR_MODE != 0) begin
          if (gnt_idx_s == SEL_W'(NUM_IN - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx_s + SEL_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset; a buffered word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: three instances (4-input round-robin, 4-input
// fixed priority, 3-input round-robin) checked against an abstract model,
// with table-driven vectors, hand sequences and a randomized phase.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NUM_IN=4, round-robin
  logic [127:0] a_data;
  logic [3:0]   a_valid, a_ready;
  logic [31:0]  a_odata;
  logic [1:0]   a_osel;
  logic         a_ovalid, a_ordy;
  // Instance B: NUM_IN=4, fixed priority
  logic [127:0] b_data;
  logic [3:0]   b_valid, b_ready;
  logic [31:0]  b_odata;
  logic [1:0]   b_osel;
  logic         b_ovalid, b_ordy;
  // Instance C: NUM_IN=3, round-robin
  logic [95:0]  c_data;
  logic [2:0]   c_valid, c_ready;
  logic [31:0]  c_odata;
  logic [1:0]   c_osel;
  logic         c_ovalid, c_ordy;

  rr_arb_mux #(.NUM_IN(4), .WIDTH(32), .RR_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_ordy));
  rr_arb_mux #(.NUM_IN(4), .WIDTH(32), .RR_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_ordy));
  rr_arb_mux #(.NUM_IN(3), .WIDTH(32), .RR_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_ordy));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model state: pointer, buffered word, its source index.
  typedef struct {
    int          ptr;
    bit          ov;
    logic [31:0] od;
    int          osel;
  } mstate_t;

  mstate_t ma, mb, mc;

  // Search order from the pointer, modulo n; -1 if nobody is valid.
  function automatic int mgrant(input int n, input bit rr, input int ptr, input logic [15:0] v);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = rr ? (ptr + k) % n : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void mstep(input int n, input bit rr, input mstate_t s,
                                input logic [15:0] v, input logic [511:0] d,
                                input bit ordy, input bit r,
                                output logic [15:0] rdy, output mstate_t nx);
    bit le;
    int g;
    le  = !s.ov || ordy;
    g   = mgrant(n, rr, s.ptr, v);
    rdy = 16'h0000;
    nx  = s;
    if (!r && le && g >= 0) rdy[g] = 1'b1;
    if (r) begin
      nx.ptr = 0; nx.ov = 1'b0; nx.od = 32'h0; nx.osel = 0;
    end else if (le) begin
      if (g >= 0) begin
        nx.ov = 1'b1; nx.od = d[g*32 +: 32]; nx.osel = g;
        if (rr) nx.ptr = (g + 1) % n;
      end else begin
        nx.ov = 1'b0;
      end
    end
  endfunction

  // One clock: check combinational accepts, take the edge, check the buffers.
  task automatic tick();
    logic [15:0] ra, rb, rc;
    mstate_t na, nb, nc;
    #1;
    mstep(4, 1'b1, ma, {12'h000, a_valid}, {384'h0, a_data}, a_ordy, rst, ra, na);
    mstep(4, 1'b0, mb, {12'h000, b_valid}, {384'h0, b_data}, b_ordy, rst, rb, nb);
    mstep(3, 1'b1, mc, {13'h0000, c_valid}, {416'h0, c_data}, c_ordy, rst, rc, nc);
    check("a_in_ready", {60'h0, a_ready}, {60'h0, ra[3:0]});
    check("b_in_ready", {60'h0, b_ready}, {60'h0, rb[3:0]});
    check("c_in_ready", {61'h0, c_ready}, {61'h0, rc[2:0]});
    @(posedge clk);
    #1;
    ma = na; mb = nb; mc = nc;
    check("a_out", {29'h0, a_ovalid, a_osel, a_odata}, {29'h0, ma.ov, 2'(ma.osel), ma.od});
    check("b_out", {29'h0, b_ovalid, b_osel, b_odata}, {29'h0, mb.ov, 2'(mb.osel), mb.od});
    check("c_out", {29'h0, c_ovalid, c_osel, c_odata}, {29'h0, mc.ov, 2'(mc.osel), mc.od});
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Vectors for instance A, data[i] = 0xA0+i, starting right after reset.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[5]  = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA2};
    tbl[10] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA3};
    tbl[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};

    ma = '{0, 1'b0, 32'h0, 0};
    mb = ma;
    mc = ma;

    // Reset held two cycles with every channel requesting.
    rst = 1'b1;
    a_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; a_valid = 4'b1111; a_ordy = 1'b1;
    b_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0}; b_valid = 4'b0000; b_ordy = 1'b1;
    c_data = {32'hC2, 32'hC1, 32'hC0};         c_valid = 3'b000;  c_ordy = 1'b1;
    tick();
    tick();
    check("rst_a_state", {29'h0, a_ovalid, a_osel, a_odata}, 64'h0);
    check("rst_a_ready", {60'h0, a_ready}, 64'h0);
    rst = 1'b0;

    // Table-driven round-robin, skip/wrap, drain-to-empty and stall vectors.
    for (int r = 0; r < 13; r++) begin
      a_valid = tbl[r].v;
      a_ordy  = tbl[r].ordy;
      #1;
      check($sformatf("tbl%0d_ready", r), {60'h0, a_ready}, {60'h0, tbl[r].rdy});
      tick();
      check($sformatf("tbl%0d_out", r), {29'h0, a_ovalid, a_osel, a_odata},
            {29'h0, tbl[r].ov, tbl[r].sel, tbl[r].d});
    end

    // Backpressure: ch2 loads, then stays put while out_ready is low.
    a_data[95:64] = 32'h1234; a_valid = 4'b0100; a_ordy = 1'b1;
    tick();
    check("bp_load", {29'h0, a_ovalid, a_osel, a_odata}, {29'h0, 1'b1, 2'd2, 32'h1234});
    a_ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold", {29'h0, a_ovalid, a_osel, a_odata}, {29'h0, 1'b1, 2'd2, 32'h1234});
      check("bp_ready", {60'h0, a_ready}, 64'h0);
    end
    a_data[95:64] = 32'h5678; a_ordy = 1'b1;
    #1;
    check("bp_release_ready", {60'h0, a_ready}, {60'h0, 4'b0100});
    tick();
    check("bp_release", {29'h0, a_ovalid, a_osel, a_odata}, {29'h0, 1'b1, 2'd2, 32'h5678});

    // Mid-operation reset drops the buffered word and the pointer.
    a_valid = 4'b1111; a_ordy = 1'b0; rst = 1'b1;
    #1;
    check("midrst_ready", {60'h0, a_ready}, 64'h0);
    tick();
    check("midrst_out", {29'h0, a_ovalid, a_osel, a_odata}, 64'h0);
    rst = 1'b0; a_ordy = 1'b1;
    #1;
    check("midrst_first_ready", {60'h0, a_ready}, {60'h0, 4'b0001});
    tick();
    check("midrst_first", {29'h0, a_ovalid, a_osel, a_odata}, {29'h0, 1'b1, 2'd0, 32'hA0});
    a_valid = 4'b0000;

    // Fixed priority: ch1 always beats ch3 until ch1 drops.
    b_valid = 4'b1010; b_ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fp_ready", {60'h0, b_ready}, {60'h0, 4'b0010});
      tick();
      check("fp_sel", {62'h0, b_osel}, 64'd1);
    end
    b_valid = 4'b1000;
    #1;
    check("fp_ch3_ready", {60'h0, b_ready}, {60'h0, 4'b1000});
    tick();
    check("fp_ch3", {30'h0, b_osel, b_odata}, {30'h0, 2'd3, 32'hB3});
    b_valid = 4'b0000;

    // Three inputs: ptr reaches 2, ch1 still wins alone, 2 -> 0 wrap.
    c_valid = 3'b010; tick(); check("n3_s1", {62'h0, c_osel}, 64'd1);
    c_valid = 3'b010; tick(); check("n3_s2", {62'h0, c_osel}, 64'd1);
    c_valid = 3'b101; tick(); check("n3_s3", {62'h0, c_osel}, 64'd2);
    c_valid = 3'b011; tick(); check("n3_s4", {62'h0, c_osel}, 64'd0);
    c_valid = 3'b011; tick(); check("n3_s5", {62'h0, c_osel}, 64'd1);
    c_valid = 3'b000;

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom % 64) == 0;
      a_valid = 4'($urandom_range(0, 15));
      b_valid = 4'($urandom_range(0, 15));
      c_valid = 3'($urandom_range(0, 7));
      a_data  = {$urandom, $urandom, $urandom, $urandom};
      b_data  = {$urandom, $urandom, $urandom, $urandom};
      c_data  = {$urandom, $urandom, $urandom};
      a_ordy  = ($urandom % 4) != 0;
      b_ordy  = ($urandom % 3) != 0;
      c_ordy  = ($urandom % 2) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
